// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared processor definitions used by the fetch stage and the control unit.
//   Holds the canonical NOP encoding presented when no instruction is
//   available, the fetch FSM state encodings and fetch buffer geometry.
//
//   Contents:
//     NOP_INSTR        addi x0,x0,0 encoding (32 bits)
//     FETCH_BUF_DEPTH  number of entries in the fetch buffer
//     FETCH_PC_STEP    byte increment between sequential fetches
//     fetch_state_e    REQ / WAIT / DROP fetch FSM states
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam int unsigned FETCH_PC_STEP   = 4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // allowed to issue a request
        FETCH_WAIT = 2'd1,  // one request outstanding, response will be kept
        FETCH_DROP = 2'd2   // one request outstanding, response is stale
    } fetch_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Request/response bus between the fetch stage and instruction memory.
//
//   Signals:
//     imem_addr    fetch address, meaningful while imem_req is high
//     imem_req     single-cycle request pulse
//     imem_rvalid  response strobe, one or more cycles after imem_req
//     imem_rdata   fetched instruction word, valid with imem_rvalid
//
//   Modports:
//     master  fetch stage side (drives addr/req)
//     slave   instruction memory side (drives rvalid/rdata)
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
);

    logic [WORDSIZE-1:0]         imem_addr;
    logic                        imem_req;
    logic                        imem_rvalid;
    logic [INSTRUCTION_SIZE-1:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rvalid,
        output imem_rdata
    );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Two-entry FIFO holding fetched {instruction, pc} pairs until the control
//   unit accepts them. The head entry is presented combinationally; when the
//   buffer is empty the head reads as the NOP encoding with pc 0.
//
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     i_push       write {i_instr, i_pc} at the tail
//     i_pop        drop the head entry (ignored when empty)
//     i_flush      discard all entries (wins over push/pop)
//     i_instr      instruction word to store
//     i_pc         address of the instruction to store
//     o_instr      head instruction (NOP when empty)
//     o_pc         head address (0 when empty)
//     o_valid      buffer holds at least one entry
//     o_count      current occupancy, 0..2
// -----------------------------------------------------------------------------
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  logic [INSTRUCTION_SIZE-1:0] i_instr,
    input  logic [WORDSIZE-1:0]         i_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instr,
    output logic [WORDSIZE-1:0]         o_pc,
    output logic                        o_valid,
    output logic [1:0]                  o_count
);

    logic [INSTRUCTION_SIZE-1:0] r_instr [FETCH_BUF_DEPTH];
    logic [WORDSIZE-1:0]         r_pc    [FETCH_BUF_DEPTH];
    logic                        r_head;
    logic [1:0]                  r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;
    logic w_tail;

    assign w_empty  = (r_count == 2'd0);
    assign w_full   = (r_count == 2'd2);
    assign w_do_pop = i_pop && !w_empty;
    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle; the freed slot is exactly the one the tail points at.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    // With two slots the tail is head for occupancy 0 or 2, head^1 for 1.
    assign w_tail = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_pop) begin
                r_head <= ~r_head;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_instr[w_tail] <= i_instr;
            r_pc[w_tail]    <= i_pc;
        end
    end

    assign o_valid = !w_empty;
    assign o_count = r_count;
    assign o_instr = w_empty ? INSTRUCTION_SIZE'(NOP_INSTR) : r_instr[r_head];
    assign o_pc    = w_empty ? '0 : r_pc[r_head];

endmodule : fetch_buffer

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: issues one instruction-memory request at a time, collects
//   responses into a two-entry buffer and presents the head to the control
//   unit. Redirects flush the buffer and retarget the fetch pc; a response
//   belonging to a request issued before a redirect is discarded.
//
//   Parameters:
//     WORDSIZE          pc / memory address width
//     INSTRUCTION_SIZE  instruction width
//     RESET_PC          first fetch address after reset
//
//   Ports:
//     clk           single clock, rising edge
//     reset         synchronous active-high reset
//     imem          instruction memory bus (master side)
//     redirect_en   branch/jump redirect request, highest priority
//     redirect_pc   redirect target (low two bits ignored)
//     stall         control unit cannot accept the head this cycle
//     instruction   head instruction (NOP when nothing valid)
//     instr_pc      address of the head instruction (0 when nothing valid)
//     instr_valid   instruction/instr_pc are valid
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    instruction_fetch_if.master         imem,
    input  logic                        redirect_en,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    input  logic                        stall,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [WORDSIZE-1:0]         instr_pc,
    output logic                        instr_valid
);

    fetch_state_e        r_state;
    fetch_state_e        w_next_state;
    logic [WORDSIZE-1:0] r_fetch_pc;
    logic [WORDSIZE-1:0] w_next_pc;
    logic [WORDSIZE-1:0] w_redirect_pc;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_count;
    logic                w_unused_lsbs;

    // Instructions are word aligned; the target's byte offset is dropped.
    assign w_redirect_pc = {redirect_pc[WORDSIZE-1:2], 2'b00};
    assign w_unused_lsbs = ^redirect_pc[1:0];

    // A redirect squashes whatever the control unit would have consumed.
    assign w_pop = instr_valid && !stall && !redirect_en;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_fetch_pc;
        w_req        = 1'b0;
        w_push       = 1'b0;

        unique case (r_state)
            FETCH_REQ: begin
                if (redirect_en) begin
                    // New target is requested no earlier than next cycle.
                    w_next_pc = w_redirect_pc;
                end else if (!reset && (w_count < 2'd2)) begin
                    // Occupancy below 2 guarantees room for the one response
                    // this request can produce.
                    w_req        = 1'b1;
                    w_next_state = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                if (redirect_en) begin
                    w_next_pc = w_redirect_pc;
                    // If the response lands this cycle it is simply not
                    // pushed; otherwise it is still in flight and must be
                    // swallowed later.
                    w_next_state = imem.imem_rvalid ? FETCH_REQ : FETCH_DROP;
                end else if (imem.imem_rvalid) begin
                    w_push       = 1'b1;
                    // Wraps modulo 2^WORDSIZE.
                    w_next_pc    = r_fetch_pc + WORDSIZE'(FETCH_PC_STEP);
                    w_next_state = FETCH_REQ;
                end
            end

            FETCH_DROP: begin
                if (redirect_en) begin
                    w_next_pc = w_redirect_pc;
                end
                // The stale response retires the outstanding request; a
                // redirect arriving alongside it must not leave us waiting
                // for a response that will never come.
                if (imem.imem_rvalid) begin
                    w_next_state = FETCH_REQ;
                end
            end

            default: begin
                w_next_state = FETCH_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH_REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;

    fetch_buffer #(
        .WORDSIZE         (WORDSIZE),
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE)
    ) u_fetch_buffer (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_en),
        .i_instr (imem.imem_rdata),
        .i_pc    (r_fetch_pc),
        .o_instr (instruction),
        .o_pc    (instr_pc),
        .o_valid (instr_valid),
        .o_count (w_count)
    );

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Scoreboard bench for instruction_fetch. A memory model answers requests
//   after a chosen latency; accepted responses are pushed as expected
//   {instruction, pc} entries and popped when the DUT hands an instruction to
//   the control unit. A second instance checks the pc wrap from the top of
//   the address space.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int          WS      = 64;
    localparam int          IS      = 32;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, RESET_PC = 0
    logic          reset;
    logic          redirect_en;
    logic [WS-1:0] redirect_pc;
    logic          stall;
    logic [IS-1:0] instruction;
    logic [WS-1:0] instr_pc;
    logic          instr_valid;

    instruction_fetch_if #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS)) mem_bus ();

    instruction_fetch #(
        .WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .RESET_PC(64'd0)
    ) u_dut (
        .clk(clk), .reset(reset), .imem(mem_bus),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    // wrap instance, RESET_PC at the top of the address space
    logic          reset2;
    logic          redirect_en2;
    logic [WS-1:0] redirect_pc2;
    logic          stall2;
    logic [IS-1:0] instruction2;
    logic [WS-1:0] instr_pc2;
    logic          instr_valid2;

    instruction_fetch_if #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS)) mem_bus2 ();

    instruction_fetch #(
        .WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .RESET_PC(WRAP_PC)
    ) u_dut_wrap (
        .clk(clk), .reset(reset2), .imem(mem_bus2),
        .redirect_en(redirect_en2), .redirect_pc(redirect_pc2), .stall(stall2),
        .instruction(instruction2), .instr_pc(instr_pc2), .instr_valid(instr_valid2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    logic        pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    logic [31:0] pend_data;
    logic        stale;
    logic [63:0] exp_pc;
    int          lat;
    int          n_req;
    logic [63:0] last_req_addr;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic        glitch;

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        case (addr)
            64'h0:   return 32'h0050_0093;
            64'h4:   return 32'h00A0_0113;
            default: return addr[31:0] ^ 32'hA5A5_0013;
        endcase
    endfunction

    // One clock cycle: drive memory response, check, bookkeep, advance.
    task automatic cycle();
        logic        deliver;
        logic [63:0] d_addr;
        logic [31:0] d_data;
        exp_t        e;
        deliver = 1'b0;
        d_addr  = '0;
        d_data  = '0;
        if (glitch) begin
            mem_bus.imem_rvalid = 1'b1;
            mem_bus.imem_rdata  = 32'hBAD0_0BAD;
        end else if (pend && pend_cnt == 0) begin
            deliver = 1'b1;
            d_addr  = pend_addr;
            d_data  = pend_data;
            pend    = 1'b0;
            mem_bus.imem_rvalid = 1'b1;
            mem_bus.imem_rdata  = d_data;
        end else begin
            mem_bus.imem_rvalid = 1'b0;
            mem_bus.imem_rdata  = '0;
        end
        #1;
        if (!reset) begin
            if (instr_valid && !stall && !redirect_en) begin
                if (sb_q.size() == 0) begin
                    check("sb_queue_nonempty", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_instr", 64'(instruction), 64'(e.instr));
                    check("sb_pc", instr_pc, e.pc);
                end
            end
            if (!instr_valid) begin
                check("empty_nop", 64'(instruction), 64'(NOP_INSTR));
                check("empty_pc", instr_pc, 64'd0);
            end
            if (redirect_en) check("no_req_on_redirect", 64'(mem_bus.imem_req), 64'd0);
            if (mem_bus.imem_req) begin
                check("req_addr", mem_bus.imem_addr, exp_pc);
                check("one_outstanding", 64'(pend), 64'd0);
                n_req++;
                last_req_addr = mem_bus.imem_addr;
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = mem_bus.imem_addr;
                pend_data = ovr_en ? ovr_data : mem_word(mem_bus.imem_addr);
                ovr_en    = 1'b0;
            end
            if (deliver) begin
                if (stale || redirect_en) begin
                    stale = 1'b0;
                end else begin
                    e.instr = d_data;
                    e.pc    = d_addr;
                    sb_q.push_back(e);
                    exp_pc = exp_pc + 64'd4;
                end
            end
            if (redirect_en) begin
                sb_q.delete();
                exp_pc = {redirect_pc[63:2], 2'b00};
                if (pend) stale = 1'b1;
            end
            if (pend) pend_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        pend        = 1'b0;
        stale       = 1'b0;
        ovr_en      = 1'b0;
        glitch      = 1'b0;
        sb_q.delete();
        cycle();
        cycle();
        check("rst_req", 64'(mem_bus.imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instruction), 64'(NOP_INSTR));
        check("rst_pc", instr_pc, 64'd0);
        reset  = 1'b0;
        exp_pc = 64'd0;
        n_req  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;
        mem_bus.imem_rvalid = 1'b0; mem_bus.imem_rdata = '0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0; pend_data = '0; stale = 1'b0;
        exp_pc = '0; lat = 2; n_req = 0; last_req_addr = '0;
        ovr_en = 1'b0; ovr_data = '0; glitch = 1'b0;
        reset2 = 1'b1; redirect_en2 = 1'b0; redirect_pc2 = '0; stall2 = 1'b0;
        mem_bus2.imem_rvalid = 1'b0; mem_bus2.imem_rdata = '0;

        // pc wrap from the top of the address space
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        #1;
        check("wrap_first_req", 64'(mem_bus2.imem_req), 64'd1);
        check("wrap_first_addr", mem_bus2.imem_addr, WRAP_PC);
        @(posedge clk); #1;
        mem_bus2.imem_rvalid = 1'b1;
        mem_bus2.imem_rdata  = 32'h0050_0093;
        @(posedge clk); #1;
        mem_bus2.imem_rvalid = 1'b0;
        #1;
        check("wrap_valid", 64'(instr_valid2), 64'd1);
        check("wrap_instr", 64'(instruction2), 64'h0050_0093);
        check("wrap_instr_pc", instr_pc2, WRAP_PC);
        check("wrap_next_req", 64'(mem_bus2.imem_req), 64'd1);
        check("wrap_next_addr", mem_bus2.imem_addr, 64'd0);

        // basic fetch, spurious rvalid in the first cycle after reset
        do_reset();
        lat = 2; glitch = 1'b1;
        cycle();
        glitch = 1'b0;
        check("a_first_req_count", 64'(n_req), 64'd1);
        check("a_first_req_addr", last_req_addr, 64'd0);
        cycle();
        cycle();
        check("a_valid", 64'(instr_valid), 64'd1);
        check("a_instr", 64'(instruction), 64'h0050_0093);
        check("a_pc", instr_pc, 64'd0);
        cycle();
        check("a_next_addr", last_req_addr, 64'd4);
        check("a_req_count", 64'(n_req), 64'd2);
        repeat (6) cycle();

        // stall holds the head; full buffer blocks a third request
        do_reset();
        stall = 1'b1; lat = 2;
        repeat (12) cycle();
        check("b_reqs_while_stalled", 64'(n_req), 64'd2);
        check("b_head_valid", 64'(instr_valid), 64'd1);
        check("b_head_instr", 64'(instruction), 64'h0050_0093);
        check("b_head_pc", instr_pc, 64'd0);
        stall = 1'b0;
        cycle();
        check("b_second_instr", 64'(instruction), 64'h00A0_0113);
        check("b_second_pc", instr_pc, 64'd4);
        repeat (6) cycle();

        // redirect while waiting; late response must be dropped
        do_reset();
        lat = 3; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        cycle();
        redirect_en = 1'b1; redirect_pc = 64'h100;
        cycle();
        redirect_en = 1'b0;
        check("c_valid_after_redirect", 64'(instr_valid), 64'd0);
        base = n_req;
        repeat (2) cycle();
        check("c_no_req_in_drop", 64'(n_req), 64'(base));
        cycle();
        check("c_req_after_drop", 64'(n_req), 64'(base + 1));
        check("c_redirect_addr", last_req_addr, 64'h100);
        repeat (8) cycle();

        // redirect coinciding with the response: no drop phase
        do_reset();
        lat = 2;
        cycle();
        cycle();
        redirect_en = 1'b1; redirect_pc = 64'h200;
        cycle();
        redirect_en = 1'b0;
        check("d_valid_after_redirect", 64'(instr_valid), 64'd0);
        base = n_req;
        cycle();
        check("d_req_immediate", 64'(n_req), 64'(base + 1));
        check("d_redirect_addr", last_req_addr, 64'h200);
        repeat (6) cycle();

        // unaligned redirect in REQ state
        do_reset();
        lat = 1;
        redirect_en = 1'b1; redirect_pc = 64'h103;
        cycle();
        redirect_en = 1'b0;
        check("e_no_req_on_redirect", 64'(n_req), 64'd0);
        cycle();
        check("e_req_count", 64'(n_req), 64'd1);
        check("e_aligned_addr", last_req_addr, 64'h100);
        repeat (6) cycle();

        // random stalls, latencies and redirects
        for (int i = 0; i < 300; i++) begin
            stall       = ($urandom_range(3) == 0);
            lat         = $urandom_range(3, 1);
            redirect_en = ($urandom_range(15) == 0);
            redirect_pc = {$urandom, $urandom};
            cycle();
        end
        redirect_en = 1'b0;
        stall = 1'b1;
        repeat (12) cycle();
        check("final_buffered", 64'(sb_q.size()), 64'd2);
        check("final_valid", 64'(instr_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_instruction_fetch
